energy_sweep_ctrl: RTL and testbench
====================================

# energy_sweep_ctrl

Sequencer that computes the total Ising energy of one spin configuration by sweeping a single `partial_energy_calc` instance over every spin index. It fetches each weight row and bias from the weight memory and accumulates the signed per-spin partial energies into a total. It returns the result over a valid/ready handshake. It sits between the spin-update engine, which supplies the configuration, and the energy monitor, which consumes the total.

## Interface
- `DATASPIN`, 256, number of spins; row index range.
- `BITJ`, 4, J precision.
- `BITH`, 4, h precision.
- `SCALING_BIT`, 5, h scaling-factor width.
- `LOCAL_ENERGY_BIT`, 16, per-spin partial energy width.
- `ENERGY_TOTAL_BIT`, 32, accumulator/output width; elaboration error if < `LOCAL_ENERGY_BIT + $clog2(DATASPIN)`.
- `DATAJ`, `DATASPIN*BITJ`, derived.
- `ADDRW`, `$clog2(DATASPIN)`, derived.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous reset, active low.
- `spin_valid_i` in 1: spin configuration offered.
- `spin_ready_o` out 1: configuration accepted (IDLE only).
- `spin_vector_i` in `DATASPIN`: spins, 1 = +1, 0 = −1.
- `hscaling_i` in `SCALING_BIT`: h scale (1/2/4/8/16), captured with the spins.
- `wreq_valid_o` out 1: weight-row request.
- `wreq_ready_i` in 1: memory accepts request.
- `wreq_addr_o` out `ADDRW`: row index.
- `wrsp_valid_i` in 1: response valid (no backpressure).
- `wrsp_weight_i` in `DATAJ`: J row.
- `wrsp_hbias_i` in `BITH` signed: h for the row.
- `energy_valid_o` out 1: total energy valid.
- `energy_ready_i` in 1: consumer accepts.
- `energy_o` out `ENERGY_TOTAL_BIT` signed: total energy.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, ACC, (PIPE if enabled), DONE.
- IDLE:
  - `spin_ready_o`=1.
  - On `spin_valid_i`: latch `spin_vector_i` and `hscaling_i`, clear the accumulator and index, go to REQ.
- REQ:
  - `wreq_valid_o`=1, `wreq_addr_o`=index.
  - On `wreq_ready_i`: go to WAIT.
  - Address and valid stay stable until accepted.
- WAIT:
  - On `wrsp_valid_i`: register the weight and hbias, go to ACC.
  - `wrsp_valid_i` in any other state is ignored.
- ACC:
  - The calc instance is driven by the latched spins, `current_spin = spins[index]`, the registered weight/hbias and the latched scaling.
  - Its output is sign-extended to `ENERGY_TOTAL_BIT` and added to the accumulator.
  - If index = `DATASPIN−1`, go to DONE; else increment index and go to REQ.
- DONE:
  - `energy_valid_o`=1, `energy_o`=accumulator, both held stable.
  - Go to IDLE when `energy_ready_i`=1.
- Arithmetic:
  - Two's complement throughout.
  - The accumulator wraps on overflow (prevented by the width check).
  - Output is the raw sum Σσ_i(Σ_j J_ij σ_j + s·h_i); no halving.
- One request outstanding at a time; responses arrive in order.

## Timing
- Reset values:
  - `spin_ready_o`=1 after reset release, since the FSM resets to IDLE.
  - `wreq_valid_o`=0, `wreq_addr_o`=0, `energy_valid_o`=0, `energy_o`=0, `busy_o`=0.
  - Accumulator, index and latched registers are all 0.
- Reset mid-sweep: immediate abort to IDLE; partial sum discarded; no `energy_valid_o`.
- Per spin with zero-wait memory (ready=1, response the cycle after acceptance): 3 cycles (REQ, WAIT, ACC).
- `energy_valid_o` rises 3·`DATASPIN`+1 cycles after the accepting `spin_valid_i` edge; each memory stall cycle adds 1.
- A new configuration can be accepted the cycle after the DONE→IDLE handshake edge.
- The calc instance is combinational; no result is used outside ACC/PIPE.

## Configuration
- `ENERGY_SWEEP_PIPE_EN` defined:
  - The calc output is registered in ACC, and the add happens in an extra PIPE state.
  - Cost is 4 cycles per spin; `energy_valid_o` at 4·`DATASPIN`+1.
- Undefined:
  - There is no PIPE state and the add happens directly in ACC.
- Function (`energy_o` value) is identical in both builds.

## Structure
- `energy_monitor_pkg` holds:
  - the FSM state enum typedef;
  - a width-check function computing the minimum `ENERGY_TOTAL_BIT`;
  - default parameter constants shared with `partial_energy_calc`.
- One sub-module, `partial_energy_calc`, instantiated once with matching parameters.

## Test plan
Bench parameters: `DATASPIN`=4, `BITJ`=4, `BITH`=4; zero-wait memory unless stated.
- All spins 1, all J=+1, h=0, scale 1 -> `energy_o`=16 at cycle 13 after acceptance (17 with `ENERGY_SWEEP_PIPE_EN`).
- All spins 0, all J=+1, h=0 -> each partial = +4, `energy_o`=16.
- All spins 1, J=0, h=+1, scale 4 -> `energy_o`=16; scale 16 -> 64.
- `wreq_ready_i` low 5 cycles on row 2 and response delayed 3 cycles on row 0:
  - result unchanged.
  - `wreq_addr_o` stable while stalled.
  - valid at cycle 13+8=21.
- `energy_ready_i` held low 10 cycles:
  - `energy_valid_o`/`energy_o` stable.
  - `spin_ready_o`=0 until the handshake.
  - A spurious `wrsp_valid_i` in DONE is ignored.
- `rst_ni` asserted during row 2:
  - all outputs return to reset values that cycle.
  - A new sweep after release gives the correct total with no residue.

Source files
------------

// File: rtl/energy_monitor_pkg.sv
// Shared types and defaults for the Ising energy sweep: FSM state encoding,
// default widths used by both the sequencer and partial_energy_calc.
package energy_monitor_pkg;

    localparam int DEF_DATASPIN         = 256;
    localparam int DEF_BITJ             = 4;
    localparam int DEF_BITH             = 4;
    localparam int DEF_SCALING_BIT      = 5;
    localparam int DEF_LOCAL_ENERGY_BIT = 16;
    localparam int DEF_ENERGY_TOTAL_BIT = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ACC  = 3'd3,
        ST_PIPE = 3'd4,
        ST_DONE = 3'd5
    } sweep_state_e;

    // Smallest accumulator that cannot overflow when summing every partial energy.
    function automatic int min_total_bits(input int dataspin, input int local_bits);
        return local_bits + $clog2(dataspin);
    endfunction

endpackage

// File: rtl/partial_energy_calc.sv
// Combinational per-spin energy: sigma_i * (sum_j J_ij*sigma_j + scale*h_i),
// with spin bit 1 meaning +1 and 0 meaning -1.
module partial_energy_calc
    import energy_monitor_pkg::*;
#(
    parameter int DATASPIN         = DEF_DATASPIN,
    parameter int BITJ             = DEF_BITJ,
    parameter int BITH             = DEF_BITH,
    parameter int SCALING_BIT      = DEF_SCALING_BIT,
    parameter int LOCAL_ENERGY_BIT = DEF_LOCAL_ENERGY_BIT,
    parameter int DATAJ            = DATASPIN * BITJ
) (
    input  logic [DATASPIN-1:0]                i_spins,
    input  logic                               i_current_spin,
    input  logic [DATAJ-1:0]                   i_weight,
    input  logic signed [BITH-1:0]             i_hbias,
    input  logic [SCALING_BIT-1:0]             i_hscaling,
    output logic signed [LOCAL_ENERGY_BIT-1:0] o_energy
);

    logic signed [LOCAL_ENERGY_BIT-1:0] w_field;
    logic signed [LOCAL_ENERGY_BIT-1:0] w_hterm;
    logic signed [LOCAL_ENERGY_BIT-1:0] w_local;

    // Weight j of the row occupies bits [j*BITJ +: BITJ].
    always_comb begin
        w_field = '0;
        for (int j = 0; j < DATASPIN; j++) begin
            if (i_spins[j])
                w_field = w_field + LOCAL_ENERGY_BIT'($signed(i_weight[j*BITJ +: BITJ]));
            else
                w_field = w_field - LOCAL_ENERGY_BIT'($signed(i_weight[j*BITJ +: BITJ]));
        end
    end

    assign w_hterm  = LOCAL_ENERGY_BIT'(i_hbias) * LOCAL_ENERGY_BIT'($signed({1'b0, i_hscaling}));
    assign w_local  = w_field + w_hterm;
    assign o_energy = i_current_spin ? w_local : -w_local;

endmodule

// File: rtl/energy_sweep_ctrl.sv
// Sweeps one partial_energy_calc over every spin, fetching weight rows from memory
// and accumulating the total Ising energy. Define ENERGY_SWEEP_PIPE_EN to register
// the partial energy and perform the add in an extra PIPE state.
module energy_sweep_ctrl
    import energy_monitor_pkg::*;
#(
    parameter int DATASPIN         = DEF_DATASPIN,
    parameter int BITJ             = DEF_BITJ,
    parameter int BITH             = DEF_BITH,
    parameter int SCALING_BIT      = DEF_SCALING_BIT,
    parameter int LOCAL_ENERGY_BIT = DEF_LOCAL_ENERGY_BIT,
    parameter int ENERGY_TOTAL_BIT = DEF_ENERGY_TOTAL_BIT,
    parameter int DATAJ            = DATASPIN * BITJ,
    parameter int ADDRW            = $clog2(DATASPIN)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               spin_valid_i,
    output logic                               spin_ready_o,
    input  logic [DATASPIN-1:0]                spin_vector_i,
    input  logic [SCALING_BIT-1:0]             hscaling_i,
    output logic                               wreq_valid_o,
    input  logic                               wreq_ready_i,
    output logic [ADDRW-1:0]                   wreq_addr_o,
    input  logic                               wrsp_valid_i,
    input  logic [DATAJ-1:0]                   wrsp_weight_i,
    input  logic signed [BITH-1:0]             wrsp_hbias_i,
    output logic                               energy_valid_o,
    input  logic                               energy_ready_i,
    output logic signed [ENERGY_TOTAL_BIT-1:0] energy_o,
    output logic                               busy_o
);

    localparam logic [ADDRW-1:0] LAST_INDEX = ADDRW'(DATASPIN - 1);

    if (ENERGY_TOTAL_BIT < min_total_bits(DATASPIN, LOCAL_ENERGY_BIT)) begin : g_width_check
        $error("energy_sweep_ctrl: ENERGY_TOTAL_BIT too narrow for DATASPIN partial sums");
    end

    sweep_state_e                       r_state;
    logic [DATASPIN-1:0]                r_spins;
    logic [SCALING_BIT-1:0]             r_scale;
    logic [DATAJ-1:0]                   r_weight;
    logic signed [BITH-1:0]             r_hbias;
    logic [ADDRW-1:0]                   r_index;
    logic signed [ENERGY_TOTAL_BIT-1:0] r_acc;
    logic signed [LOCAL_ENERGY_BIT-1:0] w_partial;
    logic signed [ENERGY_TOTAL_BIT-1:0] w_addend;

    partial_energy_calc #(
        .DATASPIN         (DATASPIN),
        .BITJ             (BITJ),
        .BITH             (BITH),
        .SCALING_BIT      (SCALING_BIT),
        .LOCAL_ENERGY_BIT (LOCAL_ENERGY_BIT),
        .DATAJ            (DATAJ)
    ) u_calc (
        .i_spins        (r_spins),
        .i_current_spin (r_spins[r_index]),
        .i_weight       (r_weight),
        .i_hbias        (r_hbias),
        .i_hscaling     (r_scale),
        .o_energy       (w_partial)
    );

`ifdef ENERGY_SWEEP_PIPE_EN
    logic signed [LOCAL_ENERGY_BIT-1:0] r_partial;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_partial <= '0;
        else if (r_state == ST_ACC)
            r_partial <= w_partial;
    end

    assign w_addend = ENERGY_TOTAL_BIT'(r_partial);
`else
    assign w_addend = ENERGY_TOTAL_BIT'(w_partial);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_spins  <= '0;
            r_scale  <= '0;
            r_weight <= '0;
            r_hbias  <= '0;
            r_index  <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (spin_valid_i) begin
                        r_spins <= spin_vector_i;
                        r_scale <= hscaling_i;
                        r_acc   <= '0;
                        r_index <= '0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (wreq_ready_i)
                        r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wrsp_valid_i) begin
                        r_weight <= wrsp_weight_i;
                        r_hbias  <= wrsp_hbias_i;
                        r_state  <= ST_ACC;
                    end
                end
`ifdef ENERGY_SWEEP_PIPE_EN
                ST_ACC: begin
                    r_state <= ST_PIPE;
                end
                ST_PIPE: begin
`else
                ST_ACC: begin
`endif
                    r_acc <= r_acc + w_addend;
                    if (r_index == LAST_INDEX) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_index <= r_index + ADDRW'(1);
                        r_state <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    if (energy_ready_i)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign spin_ready_o   = (r_state == ST_IDLE);
    assign wreq_valid_o   = (r_state == ST_REQ);
    assign wreq_addr_o    = r_index;
    assign energy_valid_o = (r_state == ST_DONE);
    assign energy_o       = r_acc;
    assign busy_o         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_energy_sweep_ctrl.sv
// Directed bench for energy_sweep_ctrl with a 4-spin configuration and a
// behavioural weight memory that can stall requests and delay responses.
module tb_energy_sweep_ctrl;

    localparam int N   = 4;
    localparam int BJ  = 4;
    localparam int BH  = 4;
    localparam int SB  = 5;
    localparam int LEB = 16;
    localparam int ETB = 32;
    localparam int AW  = 2;
`ifdef ENERGY_SWEEP_PIPE_EN
    localparam int PER_SPIN = 4;
`else
    localparam int PER_SPIN = 3;
`endif
    localparam int BASE_LAT = PER_SPIN * N + 1;

    logic                  clk;
    logic                  rst_ni;
    logic                  spin_valid_i;
    logic                  spin_ready_o;
    logic [N-1:0]          spin_vector_i;
    logic [SB-1:0]         hscaling_i;
    logic                  wreq_valid_o;
    logic                  wreq_ready_i;
    logic [AW-1:0]         wreq_addr_o;
    logic                  wrsp_valid_i;
    logic [N*BJ-1:0]       wrsp_weight_i;
    logic signed [BH-1:0]  wrsp_hbias_i;
    logic                  energy_valid_o;
    logic                  energy_ready_i;
    logic signed [ETB-1:0] energy_o;
    logic                  busy_o;

    logic [N*BJ-1:0] weightRow [N];
    logic [BH-1:0]   hbiasRow  [N];
    int reqCount;
    int stallRow;
    int stallLeft;
    int delayRow;
    int delayLeft;
    bit injectSpurious;
    int checks;
    int errors;

    energy_sweep_ctrl #(
        .DATASPIN         (N),
        .BITJ             (BJ),
        .BITH             (BH),
        .SCALING_BIT      (SB),
        .LOCAL_ENERGY_BIT (LEB),
        .ENERGY_TOTAL_BIT (ETB)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .spin_valid_i   (spin_valid_i),
        .spin_ready_o   (spin_ready_o),
        .spin_vector_i  (spin_vector_i),
        .hscaling_i     (hscaling_i),
        .wreq_valid_o   (wreq_valid_o),
        .wreq_ready_i   (wreq_ready_i),
        .wreq_addr_o    (wreq_addr_o),
        .wrsp_valid_i   (wrsp_valid_i),
        .wrsp_weight_i  (wrsp_weight_i),
        .wrsp_hbias_i   (wrsp_hbias_i),
        .energy_valid_o (energy_valid_o),
        .energy_ready_i (energy_ready_i),
        .energy_o       (energy_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic setRows(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3, input logic [3:0] h0, input logic [3:0] h1,
                           input logic [3:0] h2, input logic [3:0] h3);
        weightRow[0] = w0; weightRow[1] = w1; weightRow[2] = w2; weightRow[3] = w3;
        hbiasRow[0]  = h0; hbiasRow[1]  = h1; hbiasRow[2]  = h2; hbiasRow[3]  = h3;
    endtask

    task automatic applyStimulus(input logic [N-1:0] spins, input logic [SB-1:0] scale);
        @(negedge clk);
        checkOutput("ready_before_accept", 32'(spin_ready_o), 1);
        reqCount      = 0;
        spin_vector_i = spins;
        hscaling_i    = scale;
        spin_valid_i  = 1'b1;
        @(negedge clk);
        spin_valid_i  = 1'b0;
        spin_vector_i = '0;
        checkOutput("busy_after_accept", 32'(busy_o), 1);
    endtask

    // Cycle 1 is the accepting edge; each further negedge means one more edge passed.
    task automatic waitResult(input string tag, input int expEnergy, input int expLatency);
        int cycles;
        cycles = 1;
        while (!energy_valid_o && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_energy"}, energy_o, expEnergy);
        checkOutput({tag, "_latency"}, cycles, expLatency);
    endtask

    task automatic completeHandshake(input string tag);
        energy_ready_i = 1'b1;
        @(negedge clk);
        energy_ready_i = 1'b0;
        checkOutput({tag, "_valid_drop"}, 32'(energy_valid_o), 0);
        checkOutput({tag, "_ready_back"}, 32'(spin_ready_o), 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_spin_ready"}, 32'(spin_ready_o), 1);
        checkOutput({tag, "_wreq_valid"}, 32'(wreq_valid_o), 0);
        checkOutput({tag, "_wreq_addr"}, 32'(wreq_addr_o), 0);
        checkOutput({tag, "_energy_valid"}, 32'(energy_valid_o), 0);
        checkOutput({tag, "_energy"}, energy_o, 0);
        checkOutput({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    // Weight memory: one request at a time, response one cycle after acceptance
    // unless a stall or delay has been armed for a given request number.
    initial begin
        int rowAddr;
        int rspWait;
        wreq_ready_i  = 1'b1;
        wrsp_valid_i  = 1'b0;
        wrsp_weight_i = '0;
        wrsp_hbias_i  = '0;
        forever begin
            @(negedge clk);
            if (wreq_valid_o && rst_ni) begin
                if (reqCount == stallRow && stallLeft > 0) begin
                    wreq_ready_i = 1'b0;
                    stallLeft--;
                    checkOutput("stall_addr_stable", 32'(wreq_addr_o), stallRow);
                end else begin
                    wreq_ready_i = 1'b1;
                    rowAddr = int'(wreq_addr_o);
                    rspWait = 0;
                    if (reqCount == delayRow && delayLeft > 0) begin
                        rspWait   = delayLeft;
                        delayLeft = 0;
                    end
                    reqCount++;
                    repeat (1 + rspWait) @(negedge clk);
                    wrsp_valid_i  = 1'b1;
                    wrsp_weight_i = weightRow[rowAddr];
                    wrsp_hbias_i  = hbiasRow[rowAddr];
                    @(negedge clk);
                    wrsp_valid_i  = 1'b0;
                end
            end else begin
                wreq_ready_i = 1'b1;
                if (injectSpurious) begin
                    wrsp_valid_i   = 1'b1;
                    wrsp_weight_i  = '1;
                    wrsp_hbias_i   = 4'sh7;
                    injectSpurious = 1'b0;
                end else begin
                    wrsp_valid_i = 1'b0;
                end
            end
        end
    end

    initial begin
        int guard;
        checks         = 0;
        errors         = 0;
        reqCount       = 0;
        stallRow       = -1;
        stallLeft      = 0;
        delayRow       = -1;
        delayLeft      = 0;
        injectSpurious = 1'b0;
        rst_ni         = 1'b0;
        spin_valid_i   = 1'b0;
        spin_vector_i  = '0;
        hscaling_i     = '0;
        energy_ready_i = 1'b0;
        setRows(16'h1111, 16'h1111, 16'h1111, 16'h1111, 4'h0, 4'h0, 4'h0, 4'h0);

        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst_ni = 1'b1;

        $display("[TB] all spins +1, J=+1, h=0");
        applyStimulus(4'hF, 5'd1);
        waitResult("allup_j1", 16, BASE_LAT);
        completeHandshake("allup_j1");

        $display("[TB] all spins -1, J=+1, h=0");
        applyStimulus(4'h0, 5'd1);
        waitResult("alldown_j1", 16, BASE_LAT);
        completeHandshake("alldown_j1");

        $display("[TB] J=0, h=+1 with scale 4 and 16");
        setRows(16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h1, 4'h1, 4'h1, 4'h1);
        applyStimulus(4'hF, 5'd4);
        waitResult("hbias_s4", 16, BASE_LAT);
        completeHandshake("hbias_s4");
        applyStimulus(4'hF, 5'd16);
        waitResult("hbias_s16", 64, BASE_LAT);
        completeHandshake("hbias_s16");

        $display("[TB] negative couplings give a negative total");
        setRows(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'h0, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'hF, 5'd1);
        waitResult("neg_j", -16, BASE_LAT);
        completeHandshake("neg_j");

        $display("[TB] weight ordering: only J_i0 = 2, spin0 up");
        setRows(16'h0002, 16'h0002, 16'h0002, 16'h0002, 4'h0, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'b0001, 5'd1);
        waitResult("j_order", -4, BASE_LAT);
        completeHandshake("j_order");

        $display("[TB] mixed biases with scale 4");
        setRows(16'h1111, 16'h1111, 16'h1111, 16'h1111, 4'h1, 4'hF, 4'h2, 4'h0);
        applyStimulus(4'b0011, 5'd4);
        waitResult("mixed_h", -8, BASE_LAT);
        completeHandshake("mixed_h");

        $display("[TB] request stall on row 2, response delay on row 0");
        setRows(16'h1111, 16'h1111, 16'h1111, 16'h1111, 4'h0, 4'h0, 4'h0, 4'h0);
        stallRow  = 2;
        stallLeft = 5;
        delayRow  = 0;
        delayLeft = 3;
        applyStimulus(4'hF, 5'd1);
        waitResult("stalled", 16, BASE_LAT + 8);
        completeHandshake("stalled");
        stallRow = -1;
        delayRow = -1;

        $display("[TB] consumer backpressure with spurious response in DONE");
        applyStimulus(4'hF, 5'd1);
        waitResult("backpress", 16, BASE_LAT);
        injectSpurious = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(energy_valid_o), 1);
            checkOutput("hold_energy", energy_o, 16);
            checkOutput("hold_spin_ready", 32'(spin_ready_o), 0);
        end
        completeHandshake("backpress");

        $display("[TB] reset during row 2, then a clean sweep");
        applyStimulus(4'hF, 5'd1);
        guard = 0;
        while (!(wreq_valid_o && wreq_addr_o == 2'd2) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reach_row2", 32'(guard < 100), 1);
        rst_ni = 1'b0;
        #1;
        checkResetOutputs("midreset");
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        setRows(16'h1111, 16'h1111, 16'h1111, 16'h1111, 4'h1, 4'hF, 4'h2, 4'h0);
        applyStimulus(4'b0011, 5'd4);
        waitResult("after_reset", -8, BASE_LAT);
        completeHandshake("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
